// File: rtl/xibus_pkg.sv
// Shared types and defaults for the XiBus bus-cycle sequencer.
package xibus_pkg;

    // Sequencer states, in the order a master cycle walks through them.
    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ALOAD,
        ADDR,
        DATA,
        DONE,
        SLV
    } seq_state_t;

    localparam int XIB_ADR_CYC = 1;
    localparam int XIB_TIMEOUT = 16;

endpackage

// File: rtl/xibus_timeout_ctr.sv
// Cycle counter with synchronous clear, count enable and a terminal-count flag.
// tc is high while the counter sits at 'last', i.e. during the (last+1)-th
// enabled cycle after a clear.
module xibus_timeout_ctr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         resetl,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic         tc
);

    logic [W-1:0] cnt;

    // Count enabled cycles; reset and clear both return to zero.
    always_ff @(posedge clk) begin
        if (!resetl || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == last);

endmodule

// File: rtl/xibus_cycle_seq.sv
// XiBus bus-cycle sequencer: arbitrates local master requests against incoming
// slave accesses and steps master cycles through ARB/ALOAD/ADDR/DATA/DONE.
// Every strobe is decoded from registered state only, so no input reaches an
// output combinationally.
module xibus_cycle_seq
    import xibus_pkg::*;
#(
    parameter int ADR_CYC = XIB_ADR_CYC,
    parameter int TIMEOUT = XIB_TIMEOUT,
    parameter int TMO_W   = $clog2(TIMEOUT + 1)
) (
    input  logic       CLK,
    input  logic       RESETL,
    input  logic       MREQ,
    input  logic       MWR,
    input  logic       BGNT,
    input  logic       BSEL,
    input  logic       BSTB,
    input  logic       BACK,
    output logic       BREQ,
    output logic       MASTER,
    output logic       SLAVE,
    output logic       ADRCY,
    output logic       DTACY,
    output logic       MTM1,
    output logic       MBUSY,
    output logic       MDONE,
    output logic       MERR,
    output seq_state_t dbg_state
);

    seq_state_t state_q, state_d;
    logic       pend_q, pend_d;   // master request accepted while a slave cycle ran
    logic       mwr_q, mwr_d;     // direction captured with the accepted request
    logic       merr_q, merr_d;   // DONE was reached by timeout rather than BACK
    logic       slv_hit;
    logic       adr_tc, tmo_tc;
    logic       master_st;

    assign slv_hit = BSEL && BSTB;

    // Counts ADRCY cycles; held clear outside ADDR so each entry starts at zero.
    xibus_timeout_ctr #(.W(TMO_W)) u_adr_ctr (
        .clk    (CLK),
        .resetl (RESETL),
        .clr    (state_q != ADDR),
        .en     (state_q == ADDR),
        .last   (TMO_W'(ADR_CYC - 1)),
        .tc     (adr_tc)
    );

    // Counts DATA cycles waiting for BACK; held clear outside DATA.
    xibus_timeout_ctr #(.W(TMO_W)) u_tmo_ctr (
        .clk    (CLK),
        .resetl (RESETL),
        .clr    (state_q != DATA),
        .en     (state_q == DATA),
        .last   (TMO_W'(TIMEOUT - 1)),
        .tc     (tmo_tc)
    );

    // State and request-latch registers.
    always_ff @(posedge CLK) begin
        if (!RESETL) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            mwr_q   <= 1'b0;
            merr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            mwr_q   <= mwr_d;
            merr_q  <= merr_d;
        end
    end

    // Next-state, pending-request and completion-status logic.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        mwr_d   = mwr_q;
        merr_d  = merr_q;
        case (state_q)
            IDLE: begin
                merr_d = 1'b0;
                if (slv_hit) begin
                    // Slave wins; a simultaneous request is parked, not lost.
                    state_d = SLV;
                    if (MREQ) begin
                        pend_d = 1'b1;
                        mwr_d  = MWR;
                    end
                end else if (MREQ) begin
                    state_d = ARB;
                    mwr_d   = MWR;
                end
            end
            ARB: begin
                if (BGNT) begin
                    state_d = ALOAD;
                end else if (slv_hit) begin
                    state_d = SLV;
                    pend_d  = 1'b1;
                end
            end
            ALOAD: state_d = ADDR;
            ADDR: begin
                if (adr_tc) state_d = DATA;
            end
            DATA: begin
                // An acknowledge in the last counted cycle still counts as success.
                if (BACK) begin
                    state_d = DONE;
                    merr_d  = 1'b0;
                end else if (tmo_tc) begin
                    state_d = DONE;
                    merr_d  = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            SLV: begin
                // MBUSY is low here unless a request is already parked.
                if (MREQ && !pend_q) begin
                    pend_d = 1'b1;
                    mwr_d  = MWR;
                end
                if (!BSTB) begin
                    if (pend_q || MREQ) begin
                        state_d = ARB;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign master_st = (state_q == ALOAD) || (state_q == ADDR) || (state_q == DATA);

    assign BREQ      = (state_q == ARB) || (state_q == ALOAD);
    assign MASTER    = master_st;
    assign SLAVE     = (state_q == SLV);
    assign ADRCY     = (state_q == ADDR);
    assign DTACY     = (state_q == DATA);
    assign MTM1      = master_st && mwr_q;
    assign MBUSY     = (state_q == ARB) || master_st || ((state_q == SLV) && pend_q);
    assign MDONE     = (state_q == DONE);
    assign MERR      = (state_q == DONE) && merr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_xibus_cycle_seq.sv
// Directed bench for xibus_cycle_seq. Two instances share the stimulus:
// u_dut1 (ADR_CYC=1) and u_dut2 (ADR_CYC=2). Inputs change and outputs are
// checked on the falling edge; each test starts from a fresh reset.
module tb_xibus_cycle_seq;
    import xibus_pkg::*;

    logic CLK = 1'b0;
    logic RESETL, MREQ, MWR, BGNT, BSEL, BSTB, BACK;

    logic breq1, master1, slave1, adrcy1, dtacy1, mtm11, mbusy1, mdone1, merr1;
    logic breq2, master2, slave2, adrcy2, dtacy2, mtm12, mbusy2, mdone2, merr2;
    seq_state_t st1, st2;
    logic [8:0] o1, o2;

    int n_checks = 0;
    int n_fail   = 0;

    // Output vector order: BREQ MASTER SLAVE ADRCY DTACY MTM1 MBUSY MDONE MERR
    localparam logic [8:0] O_IDLE  = 9'b000000000;
    localparam logic [8:0] O_ARB   = 9'b100000100;
    localparam logic [8:0] O_ALDW  = 9'b110001100;
    localparam logic [8:0] O_ALDR  = 9'b110000100;
    localparam logic [8:0] O_ADRW  = 9'b010101100;
    localparam logic [8:0] O_ADRR  = 9'b010100100;
    localparam logic [8:0] O_DATW  = 9'b010011100;
    localparam logic [8:0] O_DATR  = 9'b010010100;
    localparam logic [8:0] O_DONE  = 9'b000000010;
    localparam logic [8:0] O_DERR  = 9'b000000011;
    localparam logic [8:0] O_SLVP  = 9'b001000100;

    assign o1 = {breq1, master1, slave1, adrcy1, dtacy1, mtm11, mbusy1, mdone1, merr1};
    assign o2 = {breq2, master2, slave2, adrcy2, dtacy2, mtm12, mbusy2, mdone2, merr2};

    // Clock and reset block
    always #5 CLK = ~CLK;

    xibus_cycle_seq #(.ADR_CYC(1), .TIMEOUT(16)) u_dut1 (
        .CLK(CLK), .RESETL(RESETL), .MREQ(MREQ), .MWR(MWR), .BGNT(BGNT),
        .BSEL(BSEL), .BSTB(BSTB), .BACK(BACK),
        .BREQ(breq1), .MASTER(master1), .SLAVE(slave1), .ADRCY(adrcy1),
        .DTACY(dtacy1), .MTM1(mtm11), .MBUSY(mbusy1), .MDONE(mdone1),
        .MERR(merr1), .dbg_state(st1)
    );

    xibus_cycle_seq #(.ADR_CYC(2), .TIMEOUT(16)) u_dut2 (
        .CLK(CLK), .RESETL(RESETL), .MREQ(MREQ), .MWR(MWR), .BGNT(BGNT),
        .BSEL(BSEL), .BSTB(BSTB), .BACK(BACK),
        .BREQ(breq2), .MASTER(master2), .SLAVE(slave2), .ADRCY(adrcy2),
        .DTACY(dtacy2), .MTM1(mtm12), .MBUSY(mbusy2), .MDONE(mdone2),
        .MERR(merr2), .dbg_state(st2)
    );

    task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and check one instance.
    task automatic next1(input string tag, input logic [8:0] exp);
        @(negedge CLK);
        check_eq(tag, o1, exp);
    endtask

    task automatic next2(input string tag, input logic [8:0] exp);
        @(negedge CLK);
        check_eq(tag, o2, exp);
    endtask

    // Drive all inputs idle, reset for two edges, leave at a falling edge.
    task automatic do_reset();
        @(negedge CLK);
        RESETL = 1'b0; MREQ = 1'b0; MWR = 1'b0; BGNT = 1'b0;
        BSEL = 1'b0; BSTB = 1'b0; BACK = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check_eq("reset_d1", o1, O_IDLE);
        check_eq("reset_d2", o2, O_IDLE);
        RESETL = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        // Test 1: write, BGNT high, BACK on 2nd DATA cycle; MREQ during MBUSY ignored
        do_reset();
        MREQ = 1'b1; MWR = 1'b1; BGNT = 1'b1;
        next1("wr_arb", O_ARB);      MREQ = 1'b0; MWR = 1'b0;
        next1("wr_aload", O_ALDW);
        next1("wr_addr", O_ADRW);    MREQ = 1'b1;
        next1("wr_data1", O_DATW);   MREQ = 1'b0;
        next1("wr_data2", O_DATW);   BACK = 1'b1;
        next1("wr_done", O_DONE);    BACK = 1'b0;
        next1("wr_idle", O_IDLE);
        next1("wr_idle2", O_IDLE);

        // Test 2: read on ADR_CYC=2 instance, BGNT delayed 5 cycles
        do_reset();
        MREQ = 1'b1; MWR = 1'b0; BGNT = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            next2("rd_arb", O_ARB);
            MREQ = 1'b0;
            if (i == 5) BGNT = 1'b1;
        end
        next2("rd_aload", O_ALDR);
        next2("rd_addr1", O_ADRR);
        next2("rd_addr2", O_ADRR);
        next2("rd_data", O_DATR);    BACK = 1'b1;
        next2("rd_done", O_DONE);    BACK = 1'b0;
        next2("rd_idle", O_IDLE);

        // Test 3a: timeout, BACK never asserted
        do_reset();
        MREQ = 1'b1; MWR = 1'b1; BGNT = 1'b1;
        next1("to_arb", O_ARB);      MREQ = 1'b0;
        next1("to_aload", O_ALDW);
        next1("to_addr", O_ADRW);
        for (int i = 0; i < 16; i++) next1("to_data", O_DATW);
        next1("to_done_err", O_DERR);
        next1("to_idle", O_IDLE);

        // Test 3b: BACK in the 16th DATA cycle wins over timeout
        do_reset();
        MREQ = 1'b1; MWR = 1'b1; BGNT = 1'b1;
        next1("tb_arb", O_ARB);      MREQ = 1'b0;
        next1("tb_aload", O_ALDW);
        next1("tb_addr", O_ADRW);
        for (int i = 0; i < 16; i++) begin
            next1("tb_data", O_DATW);
            if (i == 15) BACK = 1'b1;
        end
        next1("tb_done_ok", O_DONE); BACK = 1'b0;
        next1("tb_idle", O_IDLE);

        // Test 4: slave and master request in the same cycle
        do_reset();
        BSEL = 1'b1; BSTB = 1'b1; MREQ = 1'b1; MWR = 1'b1; BGNT = 1'b1;
        next1("sm_slv1", O_SLVP);    MREQ = 1'b0; MWR = 1'b0; BSEL = 1'b0;
        next1("sm_slv2", O_SLVP);
        next1("sm_slv3", O_SLVP);    BSTB = 1'b0;
        next1("sm_arb", O_ARB);
        next1("sm_aload", O_ALDW);
        next1("sm_addr", O_ADRW);
        next1("sm_data", O_DATW);    BACK = 1'b1;
        next1("sm_done", O_DONE);    BACK = 1'b0;
        next1("sm_idle", O_IDLE);

        // Test 5: slave hit during ARB without grant
        do_reset();
        MREQ = 1'b1; MWR = 1'b0; BGNT = 1'b0;
        next1("sa_arb", O_ARB);      MREQ = 1'b0; BSEL = 1'b1; BSTB = 1'b1;
        next1("sa_slv1", O_SLVP);    BSEL = 1'b0;
        next1("sa_slv2", O_SLVP);
        next1("sa_slv3", O_SLVP);    BSTB = 1'b0;
        next1("sa_arb2", O_ARB);     BGNT = 1'b1;
        next1("sa_aload", O_ALDR);
        next1("sa_addr", O_ADRR);
        next1("sa_data", O_DATR);    BACK = 1'b1;
        next1("sa_done", O_DONE);    BACK = 1'b0;
        next1("sa_idle", O_IDLE);

        // Test 6: reset during DATA, then a normal read
        do_reset();
        MREQ = 1'b1; MWR = 1'b1; BGNT = 1'b1;
        next1("rs_arb", O_ARB);      MREQ = 1'b0;
        next1("rs_aload", O_ALDW);
        next1("rs_addr", O_ADRW);
        next1("rs_data", O_DATW);    RESETL = 1'b0;
        next1("rs_cleared", O_IDLE); RESETL = 1'b1;
        next1("rs_no_done", O_IDLE); MREQ = 1'b1; MWR = 1'b0;
        next1("rs_arb2", O_ARB);     MREQ = 1'b0;
        next1("rs_aload2", O_ALDR);
        next1("rs_addr2", O_ADRR);
        next1("rs_data2", O_DATR);   BACK = 1'b1;
        next1("rs_done2", O_DONE);   BACK = 1'b0;
        next1("rs_idle2", O_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xibus_cycle_seq.md
Name: xibus_cycle_seq

Overview:
Bus-cycle sequencer for the XiBus test board. It generates the state-machine strobes SLAVE, MASTER, ADRCY, DTACY and the master transfer mode MTM1 that the misc decode PAL turns into 651/374 gating. It arbitrates between local master requests and incoming slave accesses, runs the master arbitration, address-load, address and data phases, and ends every master cycle with DONE or a timeout error.

Parameters:
ADR_CYC, 1, cycles ADRCY is held high (1..4)
TIMEOUT, 16, max DATA-phase cycles without BACK before an error (2..255)
TMO_W, $clog2(TIMEOUT+1), timeout counter width (derived)

Ports:
CLK  in  1  board clock; all state changes on rising edge
RESETL  in  1  synchronous active-low reset
MREQ  in  1  local master request pulse; accepted only while MBUSY=0
MWR  in  1  master direction, 1=write (TM1); sampled with MREQ
BGNT  in  1  bus grant from arbiter
BSEL  in  1  card-select decode for an incoming slave cycle
BSTB  in  1  bus cycle strobe; slave cycle lasts while high
BACK  in  1  target acknowledge during master data phase
BREQ  out  1  bus request to arbiter
MASTER  out  1  master transaction in progress
SLAVE  out  1  slave transaction in progress
ADRCY  out  1  master address transfer strobe
DTACY  out  1  master data transfer strobe
MTM1  out  1  latched MWR, valid while MASTER=1, else 0
MBUSY  out  1  master request accepted and not yet completed
MDONE  out  1  one-cycle pulse at end of master cycle
MERR  out  1  one-cycle pulse with MDONE when ended by timeout

Behaviour:
- Clock is CLK; reset is synchronous, active-low on RESETL. While RESETL=0 at an edge: state IDLE, every output 0, pending flag, counters and MTM1 latch cleared. Applies mid-cycle (bus released next edge, no MDONE).
- All outputs registered (Moore, decoded from state); no combinational input-to-output path.
- States: IDLE, ARB, ALOAD, ADDR, DATA, DONE, SLV.
- IDLE: BSEL&BSTB -> SLV (slave has priority over a same-cycle MREQ; that MREQ is latched as pending, MWR captured). Else MREQ -> ARB, MWR latched.
- ARB: BREQ=1, MBUSY=1. BGNT -> ALOAD. BSEL&BSTB without BGNT -> SLV, pending=1, BREQ dropped. If both, BGNT wins.
- ALOAD: one cycle, MASTER=1, ADRCY=0, DTACY=0, BREQ=1 (address register load/drive). -> ADDR.
- ADDR: MASTER=1, ADRCY=1 for exactly ADR_CYC cycles -> DATA; timeout counter cleared on entry to DATA.
- DATA: MASTER=1, DTACY=1, MTM1=latched MWR. Counter increments each DATA cycle. BACK sampled high -> DONE, MERR=0. Count reaches TIMEOUT without BACK -> DONE, MERR=1. BACK in the final counted cycle: ack wins, MERR=0.
- DONE: one cycle; MDONE=1, MERR as decided, MASTER/ADRCY/DTACY/BREQ=0, MBUSY=0 -> IDLE. New MREQ accepted in the following IDLE cycle.
- SLV: SLAVE=1, MASTER=0, BREQ=0 while BSTB=1. BSTB low -> ARB if pending (pending cleared), else IDLE. BSEL ignored inside SLV.
- Invariants: MASTER and SLAVE never both 1. ADRCY and DTACY never both 1. ADRCY/DTACY only with MASTER. MREQ while MBUSY=1 is ignored.
- Latency, BGNT already high: MREQ sampled at edge n -> ARB n+1, ALOAD n+2, ADRCY n+3, DTACY n+3+ADR_CYC.

Decomposition:
- Package xibus_pkg: state enum seq_state_t (IDLE, ARB, ALOAD, ADDR, DATA, DONE, SLV), default localparams XIB_ADR_CYC=1, XIB_TIMEOUT=16.
- Sub-module xibus_timeout_ctr: clear, enable, terminal-count flag for TMO_W bits. Used for both ADR_CYC and TIMEOUT counting, in two instances.

Test Plan:
- Write, BGNT=1, BACK on 2nd DATA cycle: MREQ=1 and MWR=1 at cycle 0. Required: BREQ@1, ALOAD@2, ADRCY@3, DTACY+MTM1@4-5, MDONE@6, MERR=0.
- Read, BGNT delayed 5 cycles, ADR_CYC=2: stays in ARB with BREQ=1, ADRCY exactly 2 cycles, MTM1=0, MDONE after BACK.
- Timeout: BACK never asserted, TIMEOUT=16. Required: DTACY high exactly 16 cycles, then MDONE=MERR=1 for one cycle, all strobes 0. Separately, BACK on the 16th cycle gives MERR=0.
- Slave vs master same cycle: BSEL=BSTB=1 with MREQ. Required: SLAVE=1 for BSTB duration, MASTER=0. After BSTB falls: ARB, then a normal master cycle using the captured MWR.
- Slave during ARB: BGNT=0, slave hit for 3 cycles. Required: BREQ drops, SLAVE 3 cycles, BREQ reasserts, completes after BGNT.
- Reset mid-DATA: RESETL=0 for one edge. Required: all outputs 0 next cycle, no MDONE, and a new MREQ afterwards runs normally.
